branch_resolve_ctrl: RTL

//  Sequences branch resolution in the ID stage of the SPARC pipeline.
//  - Owns the architectural icc register {V,C,N,Z}.
//  - Evaluates Bicc conditions against icc, or against flags forwarded from EX.
//  - Stalls ID when the condition codes are not yet available.
//  - Issues registered taken / delay-slot-annul pulses to fetch, plus a saturating taken-branch counter.

---
 rtl/branch_resolve_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller for the ID stage of the SPARC pipeline.
// Holds the architectural icc flags, evaluates Bicc conditions (optionally
// on flags forwarded from EX), stalls ID on a condition-code hazard, and
// emits registered taken / delay-slot-annul pulses plus a saturating
// taken-branch counter.
module branch_resolve_ctrl #(
  parameter int unsigned CC_FWD = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             ex_cc_we_i,
  input  logic [3:0]       ex_flags_i,
  input  logic             id_valid_i,
  input  logic             id_branch_i,
  input  logic [3:0]       id_cond_i,
  input  logic             id_annul_i,
  output logic             stall_o,
  output logic             branch_taken_o,
  output logic             annul_slot_o,
  output logic [3:0]       icc_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_CC = 1'b1
  } state_e;

  localparam bit FwdEn = (CC_FWD != 0);

  // Bicc "branch always": the only taken condition that still annuls with a=1.
  localparam logic [3:0] CondBa = 4'b1000;

  state_e           state_q, state_d;
  logic [3:0]       icc_q, icc_d;
  logic             branchTaken_q, branchTaken_d;
  logic             annulSlot_q, annulSlot_d;
  logic [CNT_W-1:0] takenCnt_q, takenCnt_d;

  logic       branchValid;
  logic       ccHazard;
  logic [3:0] effFlags;
  logic       flagZ, flagN, flagC, flagV;
  logic       condBase;
  logic       condTrue;
  logic       annulNow;

  // Pick the flags the branch sees and evaluate the Bicc condition on them.
  always_comb begin
    branchValid = id_valid_i & id_branch_i;
    ccHazard    = branchValid & ex_cc_we_i & ~FwdEn;
    if ((state_q == IDLE) && FwdEn && ex_cc_we_i) begin
      effFlags = ex_flags_i;
    end else begin
      effFlags = icc_q;
    end
    flagZ = effFlags[0];
    flagN = effFlags[1];
    flagC = effFlags[2];
    flagV = effFlags[3];
    condBase = 1'b0;
    unique case (id_cond_i[2:0])
      3'b000:  condBase = 1'b0;
      3'b001:  condBase = flagZ;
      3'b010:  condBase = flagZ | (flagN ^ flagV);
      3'b011:  condBase = flagN ^ flagV;
      3'b100:  condBase = flagC | flagZ;
      3'b101:  condBase = flagC;
      3'b110:  condBase = flagN;
      3'b111:  condBase = flagV;
      default: condBase = 1'b0;
    endcase
    condTrue = condBase ^ id_cond_i[3];
    annulNow = id_annul_i & (~condTrue | (id_cond_i == CondBa));
  end

  // Stall only from IDLE on a hazard, never under flush or reset.
  always_comb begin
    stall_o = rst_ni & ~flush_i & (state_q == IDLE) & ccHazard;
  end

  // Next-state, next-pulse, icc and counter update; flush overrides everything.
  always_comb begin
    state_d       = state_q;
    branchTaken_d = 1'b0;
    annulSlot_d   = 1'b0;
    icc_d         = icc_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      if (ex_cc_we_i) begin
        icc_d = ex_flags_i;
      end
      unique case (state_q)
        IDLE: begin
          if (ccHazard) begin
            state_d = WAIT_CC;
          end else if (branchValid) begin
            branchTaken_d = condTrue;
            annulSlot_d   = annulNow;
          end
        end
        WAIT_CC: begin
          state_d = IDLE;
          if (branchValid) begin
            branchTaken_d = condTrue;
            annulSlot_d   = annulNow;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (branchTaken_d && (takenCnt_q != {CNT_W{1'b1}})) begin
      takenCnt_d = takenCnt_q + CNT_W'(1);
    end else begin
      takenCnt_d = takenCnt_q;
    end
  end

  // All state and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      icc_q         <= 4'b0000;
      branchTaken_q <= 1'b0;
      annulSlot_q   <= 1'b0;
      takenCnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      icc_q         <= icc_d;
      branchTaken_q <= branchTaken_d;
      annulSlot_q   <= annulSlot_d;
      takenCnt_q    <= takenCnt_d;
    end
  end

  assign branch_taken_o = branchTaken_q;
  assign annul_slot_o   = annulSlot_q;
  assign icc_o          = icc_q;
  assign taken_cnt_o    = takenCnt_q;

endmodule
